// File: rtl/nonce_collector_if.sv
// nonce_collector_if
//   Bundles the nonce-source bus and the serial_transmit handshake of the
//   nonce collector.
//
//   Parameters: SLAVES (nonce sources), FIFO_LOG2 (log2 FIFO depth),
//               DROP_W (dropped-nonce counter width).
//
//   Signals:
//     new_nonces    per-slave one-cycle strobe
//     slave_nonces  slave i nonce at [i*32+31:i*32]
//     serial_busy   high while serial_transmit shifts a word
//     serial_send   one-cycle start pulse to serial_transmit
//     golden_nonce  word to transmit
//     fifo_level    result FIFO occupancy
//     drop_count    saturating count of lost nonces
//
//   Modports:
//     master  hub side: drives the nonce sources and serial_busy
//     slave   collector side: consumes nonces, drives the transmit side
interface nonce_collector_if #(
    parameter int unsigned SLAVES    = 4,
    parameter int unsigned FIFO_LOG2 = 3,
    parameter int unsigned DROP_W    = 8
);
    logic [SLAVES-1:0]    new_nonces;
    logic [SLAVES*32-1:0] slave_nonces;
    logic                 serial_busy;
    logic                 serial_send;
    logic [31:0]          golden_nonce;
    logic [FIFO_LOG2:0]   fifo_level;
    logic [DROP_W-1:0]    drop_count;

    modport master (
        output new_nonces,
        output slave_nonces,
        output serial_busy,
        input  serial_send,
        input  golden_nonce,
        input  fifo_level,
        input  drop_count
    );

    modport slave (
        input  new_nonces,
        input  slave_nonces,
        input  serial_busy,
        output serial_send,
        output golden_nonce,
        output fifo_level,
        output drop_count
    );
endinterface

// File: rtl/nonce_collector.sv
// nonce_collector
//   Collects golden nonces from all hub slaves and serialises them onto the
//   single upstream serial_transmit link.
//
//   Datapath: per-slave hold register + pending flag -> round-robin arbiter
//   -> result FIFO (2**FIFO_LOG2 deep) -> send/busy handshake FSM.
//
//   Ports:
//     hash_clk  sole clock, rising edge
//     reset     asynchronous, active-high; clears all state
//     bus       nonce_collector_if.slave (nonce inputs, serial_busy in;
//               serial_send, golden_nonce, fifo_level, drop_count out)
//
//   Optional feature: define NONCE_DEDUP_EN to discard a granted nonce equal
//   to the last one pushed into the FIFO.
module nonce_collector #(
    parameter int unsigned SLAVES    = 4,
    parameter int unsigned FIFO_LOG2 = 3,
    parameter int unsigned DROP_W    = 8
) (
    input  logic             hash_clk,
    input  logic             reset,
    nonce_collector_if.slave bus
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned PTR_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int unsigned CNT_W = $clog2(SLAVES + 1);
    localparam int unsigned SUM_W = DROP_W + CNT_W;

    typedef enum logic [1:0] {
        StIdle,
        StWaitHi,
        StWaitLo
    } state_e;

    // Capture stage
    logic [31:0]       hold_q [SLAVES];
    logic [SLAVES-1:0] pending_q;
    logic [SLAVES-1:0] pending_d;
    logic [SLAVES-1:0] grant_oh;
    logic [SLAVES-1:0] drop_vec;

    // Arbiter
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  rr_ptr_d;
    logic              grant_valid;
    logic [PTR_W-1:0]  grant_idx;
    logic [31:0]       grant_nonce;
    logic              push;

    // Result FIFO
    logic [31:0]          fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q;
    logic [FIFO_LOG2-1:0] rd_ptr_q;
    logic [FIFO_LOG2:0]   level_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    // Drop counter
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;
    logic [SUM_W-1:0]  drop_sum;

    // Transmit FSM
    state_e      state_q;
    state_e      state_d;
    logic [1:0]  hi_cnt_q;
    logic [1:0]  hi_cnt_d;
    logic        send_q;
    logic [31:0] golden_q;

    // ------------------------------------------------------------------
    // Arbiter: first pending slave at or after rr_ptr_q, wrapping.
    // No grant at all while the FIFO is full, so it can never overflow.
    // ------------------------------------------------------------------
    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < SLAVES; k++) begin
            idx = k + 32'(rr_ptr_q);
            if (idx >= SLAVES) begin
                idx = idx - SLAVES;
            end
            if (!grant_valid && !fifo_full && pending_q[PTR_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    assign grant_nonce = hold_q[grant_idx];
    assign grant_oh    = grant_valid ? (SLAVES'(1) << grant_idx) : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == PTR_W'(SLAVES - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef NONCE_DEDUP_EN
    // Last value pushed; only a push updates it, only reset clears it.
    logic [31:0] last_q;
    logic        last_vld_q;
    logic        dup;

    assign dup  = last_vld_q && (last_q == grant_nonce);
    assign push = grant_valid && !dup;

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (push) begin
            last_q     <= grant_nonce;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign push = grant_valid;
`endif

    // ------------------------------------------------------------------
    // Capture: a strobe on the slave being granted this cycle is not a
    // drop -- the old value leaves through the grant, the new one loads.
    // ------------------------------------------------------------------
    assign pending_d = (pending_q & ~grant_oh) | bus.new_nonces;
    assign drop_vec  = bus.new_nonces & pending_q & ~grant_oh;

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            rr_ptr_q  <= '0;
            for (int unsigned i = 0; i < SLAVES; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            for (int unsigned i = 0; i < SLAVES; i++) begin
                if (bus.new_nonces[i]) begin
                    hold_q[i] <= bus.slave_nonces[i*32 +: 32];
                end
            end
        end
    end

    // Several slaves can drop in the same cycle; add them all, then saturate.
    always_comb begin
        drop_sum = SUM_W'(drop_q);
        for (int unsigned i = 0; i < SLAVES; i++) begin
            drop_sum = drop_sum + SUM_W'(drop_vec[i]);
        end
        if (drop_sum > SUM_W'({DROP_W{1'b1}})) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[DROP_W-1:0];
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO: head is read combinationally at fifo_mem[rd_ptr_q].
    // ------------------------------------------------------------------
    assign fifo_full  = (level_q == (FIFO_LOG2 + 1)'(DEPTH));
    assign fifo_empty = (level_q == '0);

    always_ff @(posedge hash_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= grant_nonce;
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM. WAIT_HI gives the link 4 cycles to raise busy before
    // assuming it is dead and moving on, so a lost word cannot stall us.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        hi_cnt_d = hi_cnt_q;
        pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !bus.serial_busy) begin
                    pop      = 1'b1;
                    hi_cnt_d = '0;
                    state_d  = StWaitHi;
                end
            end
            StWaitHi: begin
                if (bus.serial_busy || (hi_cnt_q == 2'd3)) begin
                    state_d = StWaitLo;
                end else begin
                    hi_cnt_d = hi_cnt_q + 1'b1;
                end
            end
            StWaitLo: begin
                if (!bus.serial_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            hi_cnt_q <= '0;
            send_q   <= 1'b0;
            golden_q <= '0;
        end else begin
            state_q  <= state_d;
            hi_cnt_q <= hi_cnt_d;
            send_q   <= pop;
            // golden_nonce only ever moves on a pop, so it stays stable
            // for the whole time serial_transmit is shifting it out.
            if (pop) begin
                golden_q <= fifo_mem[rd_ptr_q];
            end
        end
    end

    assign bus.serial_send  = send_q;
    assign bus.golden_nonce = golden_q;
    assign bus.fifo_level   = level_q;
    assign bus.drop_count   = drop_q;

endmodule

// File: tb/tb_nonce_collector.sv
// tb_nonce_collector
//   Drives nonce_collector through directed scenarios and a randomized run.
//   A queue-based reference model (per-slave hold/pending, a FIFO queue and a
//   drop count) predicts fifo_level, drop_count and every transmitted word;
//   pop timing is taken from the observed serial_send pulse.
module tb_nonce_collector;
    localparam int unsigned SLAVES    = 4;
    localparam int unsigned FIFO_LOG2 = 3;
    localparam int unsigned DROP_W    = 8;
    localparam int unsigned DEPTH     = 1 << FIFO_LOG2;

    logic hash_clk = 1'b0;
    logic reset;

    always #5 hash_clk = ~hash_clk;

    nonce_collector_if #(.SLAVES(SLAVES), .FIFO_LOG2(FIFO_LOG2), .DROP_W(DROP_W)) bus ();

    nonce_collector #(
        .SLAVES   (SLAVES),
        .FIFO_LOG2(FIFO_LOG2),
        .DROP_W   (DROP_W)
    ) dut (
        .hash_clk(hash_clk),
        .reset   (reset),
        .bus     (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cycle   = 0;
    int send_cycle = -1;

    // Reference model state
    logic [31:0] m_hold [SLAVES];
    bit          m_pend [SLAVES];
    int          m_ptr;
    logic [31:0] m_q [$];
    int          m_drop;
    logic [31:0] m_golden;
    logic [31:0] tx_log [$];
`ifdef NONCE_DEDUP_EN
    logic [31:0] m_last;
    bit          m_last_vld;
`endif

    // Link model
    bit hold_busy = 1'b0;
    bit dead_link = 1'b0;
    int busy_len  = 3;
    int busy_rem  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < SLAVES; i++) begin
            if (m_pend[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SLAVES; i++) begin
            m_hold[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_ptr    = 0;
        m_q.delete();
        tx_log.delete();
        m_drop   = 0;
        m_golden = '0;
`ifdef NONCE_DEDUP_EN
        m_last     = '0;
        m_last_vld = 1'b0;
`endif
    endtask

    // Advance the model by the clock edge just taken and check the outputs.
    task automatic model_step();
        int          g;
        logic [31:0] gv;
        bit          do_push;
        g = -1;
        if (m_q.size() < DEPTH) begin
            for (int k = 0; k < SLAVES; k++) begin
                int idx;
                idx = (m_ptr + k) % SLAVES;
                if (g < 0 && m_pend[idx]) g = idx;
            end
        end
        if (bus.serial_send) begin
            check_eq("send_busy", bus.serial_busy, 0);
            if (m_q.size() == 0) begin
                check_eq("spurious_send", 1, 0);
            end else begin
                m_golden = m_q.pop_front();
                tx_log.push_back(m_golden);
            end
        end
        if (g >= 0) begin
            gv      = m_hold[g];
            do_push = 1'b1;
`ifdef NONCE_DEDUP_EN
            if (m_last_vld && m_last == gv) do_push = 1'b0;
            if (do_push) begin
                m_last     = gv;
                m_last_vld = 1'b1;
            end
`endif
            if (do_push) m_q.push_back(gv);
            m_pend[g] = 1'b0;
            m_ptr     = (g + 1) % SLAVES;
        end
        for (int i = 0; i < SLAVES; i++) begin
            if (bus.new_nonces[i]) begin
                if (m_pend[i] && m_drop < (1 << DROP_W) - 1) m_drop++;
                m_hold[i] = bus.slave_nonces[i*32 +: 32];
                m_pend[i] = 1'b1;
            end
        end
        check_eq("golden", bus.golden_nonce, m_golden);
        check_eq("level", bus.fifo_level, m_q.size());
        check_eq("drop", bus.drop_count, m_drop);
    endtask

    task automatic tick();
        @(posedge hash_clk);
        cycle++;
        @(negedge hash_clk);
        model_step();
        if (bus.serial_send) send_cycle = cycle;
        if (bus.serial_send && !dead_link) busy_rem = busy_len;
        else if (busy_rem > 0) busy_rem--;
        bus.serial_busy = hold_busy || (busy_rem > 0);
        bus.new_nonces  = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input int i, input logic [31:0] v);
        bus.new_nonces[i]            = 1'b1;
        bus.slave_nonces[i*32 +: 32] = v;
    endtask

    task automatic wait_sends(input int n, input int budget);
        int b;
        b = 0;
        while (tx_log.size() < n && b < budget) begin
            tick();
            b++;
        end
        check_eq("tx_count", tx_log.size(), n);
    endtask

    // Called at a negedge: asserts reset, checks the cleared outputs and
    // releases reset one cycle later.
    task automatic apply_reset();
        reset            = 1'b1;
        bus.new_nonces   = '0;
        bus.slave_nonces = '0;
        hold_busy        = 1'b0;
        dead_link        = 1'b0;
        busy_rem         = 0;
        bus.serial_busy  = 1'b0;
        #1;
        check_eq("rst_send", bus.serial_send, 0);
        check_eq("rst_golden", bus.golden_nonce, 0);
        check_eq("rst_level", bus.fifo_level, 0);
        check_eq("rst_drop", bus.drop_count, 0);
        model_clear();
        @(negedge hash_clk);
        reset      = 1'b0;
        cycle      = 0;
        send_cycle = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        bus.new_nonces   = '0;
        bus.slave_nonces = '0;
        bus.serial_busy  = 1'b0;
        @(negedge hash_clk);
        apply_reset();

        // Single nonce, latency and long busy
        busy_len = 40;
        run(9);
        strobe(2, 32'hDEADBEEF);
        tick();
        run(2);
        check_eq("send_cycle", send_cycle, 12);
        check_eq("golden_first", bus.golden_nonce, 32'hDEADBEEF);
        wait_sends(1, 100);
        run(45);
        check_eq("lvl_after", bus.fifo_level, 0);
        check_eq("drop_after", bus.drop_count, 0);

        // All four slaves at once, round-robin order
        @(negedge hash_clk);
        apply_reset();
        busy_len = 5;
        for (int i = 0; i < SLAVES; i++) strobe(i, 32'h100 + i);
        tick();
        wait_sends(4, 300);
        for (int k = 0; k < 4; k++) check_eq("rr_order", tx_log[k], 32'h100 + k);

        // Overwrite while FIFO full
        apply_reset();
        hold_busy       = 1'b1;
        bus.serial_busy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            strobe(0, 32'h2000 + k);
            run(2);
        end
        check_eq("full_level", bus.fifo_level, 8);
        strobe(1, 32'hA0);
        run(2);
        strobe(1, 32'hA1);
        run(2);
        check_eq("ovw_drop", bus.drop_count, 1);
        hold_busy = 1'b0;
        busy_len  = 2;
        wait_sends(9, 400);
        check_eq("ovw_last", tx_log[8], 32'hA1);

        // Same pair with room in the FIFO
        apply_reset();
        busy_len = 3;
        strobe(1, 32'hA0);
        run(3);
        strobe(1, 32'hA1);
        tick();
        wait_sends(2, 200);
        check_eq("pair0", tx_log[0], 32'hA0);
        check_eq("pair1", tx_log[1], 32'hA1);
        check_eq("pair_drop", bus.drop_count, 0);

        // FIFO saturation with 12 arrivals
        apply_reset();
        hold_busy       = 1'b1;
        bus.serial_busy = 1'b1;
        for (int k = 0; k < 12; k++) begin
            strobe(0, 32'h1000 + k);
            run(3);
        end
        check_eq("sat_level", bus.fifo_level, 8);
        check_eq("sat_drop", bus.drop_count, 3);
        hold_busy = 1'b0;
        busy_len  = 2;
        wait_sends(9, 500);
        for (int k = 0; k < 8; k++) check_eq("sat_order", tx_log[k], 32'h1000 + k);
        check_eq("sat_last", tx_log[8], 32'h100B);

        // Reset while waiting for busy to fall with 5 words queued
        apply_reset();
        busy_len = 60;
        strobe(0, 32'h3000);
        run(4);
        for (int k = 0; k < 5; k++) begin
            strobe(k % SLAVES, 32'h3001 + k);
            run(2);
        end
        check_eq("pre_rst_level", bus.fifo_level, 5);
        check_eq("pre_rst_busy", bus.serial_busy, 1);
        apply_reset();
        run(30);
        check_eq("post_rst_sends", tx_log.size(), 0);

        // Duplicate nonce from two slaves
        apply_reset();
        busy_len = 3;
        strobe(0, 32'h55);
        run(5);
        strobe(3, 32'h55);
        run(60);
`ifdef NONCE_DEDUP_EN
        check_eq("dup_sends", tx_log.size(), 1);
`else
        check_eq("dup_sends", tx_log.size(), 2);
`endif

        // Randomized traffic, busy lengths, dead link and stalls
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 2) hold_busy = !hold_busy;
            busy_len  = int'($urandom_range(1, 6));
            dead_link = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < SLAVES; i++) begin
                if ($urandom_range(0, 5) == 0) strobe(i, $urandom);
            end
            tick();
        end
        hold_busy = 1'b0;
        dead_link = 1'b0;
        begin
            int b;
            b = 0;
            while ((m_q.size() > 0 || any_pending()) && b < 2000) begin
                tick();
                b++;
            end
            check_eq("drain", m_q.size() + int'(any_pending()), 0);
        end
        run(20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
